// File: rtl/dmem_copy_arbiter.sv
// Shares the 8-bit x 256 data memory port between the core (priority) and a byte block-copy engine.
// Optional fill mode is compiled in with `define DMEM_FILL_EN.
module dmem_copy_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CoreReq,
  input  logic       CoreWe,
  input  logic [7:0] CoreAddr,
  input  logic [7:0] CoreWData,
  output logic       CoreGnt,
  output logic [7:0] CoreRData,
  input  logic       DmaStart,
  input  logic [7:0] DmaSrc,
  input  logic [7:0] DmaDst,
  input  logic [7:0] DmaLen,
`ifdef DMEM_FILL_EN
  input  logic       DmaFill,
  input  logic [7:0] DmaFillVal,
`endif
  output logic       DmaBusy,
  output logic       DmaDone,
  output logic       MemWriteEn,
  output logic [7:0] MemAddr,
  output logic [7:0] MemWData,
  input  logic [7:0] MemDataOut
);

  localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    dst_q, dst_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    buf_q, buf_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          fill_q, fill_d;
  logic [7:0]    fill_val_q, fill_val_d;

  logic       copy_active;
  logic       force_copy;
  logic       dma_gnt;
  logic       start_fill;
  logic [7:0] start_fill_val;
  logic [7:0] wr_data;

`ifdef DMEM_FILL_EN
  assign start_fill     = DmaFill;
  assign start_fill_val = DmaFillVal;
`else
  assign start_fill     = 1'b0;
  assign start_fill_val = 8'h00;
`endif

  assign copy_active = (state_q == S_RD) || (state_q == S_WR);
  assign force_copy  = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX) && copy_active;
  assign CoreGnt     = CoreReq && !force_copy;
  assign dma_gnt     = copy_active && !CoreGnt;
  assign wr_data     = fill_q ? fill_val_q : buf_q;

  assign CoreRData = MemDataOut;
  assign DmaBusy   = (state_q != S_IDLE);
  assign DmaDone   = (state_q == S_DONE);

  // Idle port defaults to the core address so a dropped core request still sees sane read data.
  always_comb begin
    MemAddr  = CoreAddr;
    MemWData = CoreWData;
    if (dma_gnt) begin
      MemAddr  = (state_q == S_RD) ? src_q : dst_q;
      MemWData = wr_data;
    end
  end

  assign MemWriteEn = !Reset && ((CoreGnt && CoreWe) || (dma_gnt && (state_q == S_WR)));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    case (state_q)
      S_IDLE: begin
        if (DmaStart) begin
          src_d      = DmaSrc;
          dst_d      = DmaDst;
          rem_d      = DmaLen;
          fill_d     = start_fill;
          fill_val_d = start_fill_val;
          if (DmaLen == 8'd0)  state_d = S_DONE;
          else if (start_fill) state_d = S_WR;
          else                 state_d = S_RD;
        end
      end
      S_RD: begin
        if (dma_gnt) begin
          buf_d   = MemDataOut;
          src_d   = src_q + 8'd1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (dma_gnt) begin
          dst_d = dst_q + 8'd1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_DONE;
          else if (fill_q)   state_d = S_WR;
          else               state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Starvation counter only accumulates while the engine waits behind a granted core access.
  always_comb begin
    starve_d = starve_q;
    if ((state_q == S_IDLE) || dma_gnt)
      starve_d = '0;
    else if (copy_active && CoreGnt && (starve_q != STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      src_q      <= 8'd0;
      dst_q      <= 8'd0;
      rem_q      <= 8'd0;
      buf_q      <= 8'd0;
      starve_q   <= '0;
      fill_q     <= 1'b0;
      fill_val_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      buf_q      <= buf_d;
      starve_q   <= starve_d;
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end

endmodule

// File: tb/tb_dmem_copy_arbiter.sv
// Self-checking bench for dmem_copy_arbiter: randomized copies against a forward-copy reference model.
// Fill-mode scenarios are included when DMEM_FILL_EN is defined.
module tb_dmem_copy_arbiter;
  localparam int LIM = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CoreReq, CoreWe;
  logic [7:0] CoreAddr, CoreWData;
  logic       CoreGnt;
  logic [7:0] CoreRData;
  logic       DmaStart;
  logic [7:0] DmaSrc, DmaDst, DmaLen;
  logic       DmaFill;
  logic [7:0] DmaFillVal;
  logic       DmaBusy, DmaDone, MemWriteEn;
  logic [7:0] MemAddr, MemWData, MemDataOut;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  dmem_copy_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .Clk(Clk), .Reset(Reset),
    .CoreReq(CoreReq), .CoreWe(CoreWe), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
    .CoreGnt(CoreGnt), .CoreRData(CoreRData),
    .DmaStart(DmaStart), .DmaSrc(DmaSrc), .DmaDst(DmaDst), .DmaLen(DmaLen),
`ifdef DMEM_FILL_EN
    .DmaFill(DmaFill), .DmaFillVal(DmaFillVal),
`endif
    .DmaBusy(DmaBusy), .DmaDone(DmaDone), .MemWriteEn(MemWriteEn),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemDataOut(MemDataOut)
  );

  // Environment memory: combinational read, clocked write, plus a bench preload path.
  assign MemDataOut = mem[MemAddr];
  always @(posedge Clk) begin
    if (pre_we)          mem[pre_addr] <= pre_data;
    else if (MemWriteEn) mem[MemAddr]  <= MemWData;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge Clk); #1;
    pre_we = 1'b0;
  endtask

  // mode: 0 no core traffic, 1 random core reads, 2 core requesting every cycle.
  // poke_busy pulses DmaStart with unrelated parameters while the copy runs.
  task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                          input bit fill, input logic [7:0] fv, input int mode, input bit poke_busy);
    logic [7:0] exp_mem [256];
    int rd_q[$];
    int wr_q[$];
    int wd_q[$];
    int cyc, limit, grants, gnt_err, core_err, bad, exp_cyc;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < int'(len); i++)
      exp_mem[8'(dst + 8'(i))] = fill ? fv : exp_mem[8'(src + 8'(i))];
    grants   = fill ? int'(len) : 2 * int'(len);
    limit    = grants * (LIM + 1) + 4;
    gnt_err  = 0;
    core_err = 0;
    CoreReq = 1'b0; CoreWe = 1'b0;
    DmaSrc = src; DmaDst = dst; DmaLen = len; DmaFill = fill; DmaFillVal = fv;
    DmaStart = 1'b1;
    @(posedge Clk); #1;
    DmaStart = 1'b0;
    cyc = 1;
    forever begin
      CoreWe   = 1'b0;
      CoreAddr = 8'($urandom);
      case (mode)
        1:       CoreReq = 1'($urandom_range(0, 1));
        2:       CoreReq = 1'b1;
        default: CoreReq = 1'b0;
      endcase
      DmaStart = poke_busy && (cyc == 2);
      if (DmaStart) begin
        DmaSrc = 8'($urandom); DmaDst = 8'($urandom); DmaLen = 8'($urandom_range(1, 9));
      end
      #1;
      if (DmaDone || cyc > limit) break;
      if (CoreGnt && (MemAddr !== CoreAddr || CoreRData !== mem[CoreAddr] || MemWriteEn)) core_err++;
      if (mode == 2 && CoreGnt !== ((cyc % (LIM + 1)) != 0)) gnt_err++;
      if (!CoreGnt) begin
        if (MemWriteEn) begin
          wr_q.push_back(int'(MemAddr));
          wd_q.push_back(int'(MemWData));
        end else begin
          rd_q.push_back(int'(MemAddr));
        end
      end
      @(posedge Clk); #1;
      cyc++;
    end
    DmaStart = 1'b0;
    CoreReq  = 1'b0;
    check_eq("done", {31'd0, DmaDone}, 32'd1);
    if (len == 8'd0)    exp_cyc = 1;
    else if (mode == 0) exp_cyc = grants + 1;
    else if (mode == 2) exp_cyc = grants * (LIM + 1) + 1;
    else                exp_cyc = -1;
    if (exp_cyc > 0) check_eq("latency", cyc, exp_cyc);
    check_eq("core_port", core_err, 0);
    if (mode == 2) check_eq("gnt_pattern", gnt_err, 0);
    check_eq("wr_count", wr_q.size(), int'(len));
    check_eq("rd_count", rd_q.size(), fill ? 0 : int'(len));
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (wr_q[i] != int'(8'(dst + 8'(i)))) bad++;
      if (wd_q[i] != int'(exp_mem[8'(dst + 8'(i))])) bad++;
    end
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] != int'(8'(src + 8'(i)))) bad++;
    check_eq("addr_seq", bad, 0);
    @(posedge Clk); #1;
    check_eq("done_pulse", {31'd0, DmaDone}, 32'd0);
    check_eq("idle_busy", {31'd0, DmaBusy}, 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_eq("mem", bad, 0);
    $display("copy src=%02h dst=%02h len=%0d fill=%0d mode=%0d cycles=%0d", src, dst, len, fill, mode, cyc);
  endtask

  initial begin
    bit fl;
    Reset = 1'b1; CoreReq = 1'b1; CoreWe = 1'b1; CoreAddr = 8'h00; CoreWData = 8'hFF;
    DmaStart = 1'b0; DmaSrc = 8'h00; DmaDst = 8'h00; DmaLen = 8'h00;
    DmaFill = 1'b0; DmaFillVal = 8'h00; pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_busy", {31'd0, DmaBusy}, 32'd0);
    check_eq("rst_done", {31'd0, DmaDone}, 32'd0);
    check_eq("rst_we", {31'd0, MemWriteEn}, 32'd0);
    Reset = 1'b0; CoreReq = 1'b0; CoreWe = 1'b0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // Core write then read while idle
    CoreReq = 1'b1; CoreWe = 1'b1; CoreAddr = 8'h33; CoreWData = 8'h5A;
    #1;
    check_eq("core_gnt", {31'd0, CoreGnt}, 32'd1);
    check_eq("core_we", {31'd0, MemWriteEn}, 32'd1);
    @(posedge Clk); #1;
    CoreWe = 1'b0;
    #1;
    check_eq("core_rd", {24'd0, CoreRData}, 32'h5A);
    CoreReq = 1'b0;
    $display("core write/read addr=33 data=5a");

    // Uncontended copy
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    run_copy(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 0, 1'b0);
    check_eq("copy_b3", {24'd0, mem[8'h83]}, 32'hD4);
    // Wrap and zero length
    run_copy(8'hFE, 8'h02, 8'd3, 1'b0, 8'h00, 0, 1'b0);
    run_copy(8'h40, 8'h50, 8'd0, 1'b0, 8'h00, 0, 1'b0);
    // Contention with core requesting continuously
    run_copy(8'h60, 8'h70, 8'd2, 1'b0, 8'h00, 2, 1'b0);
    // Overlapping forward copy with a start pulse during busy
    poke(8'h20, 8'h55);
    run_copy(8'h20, 8'h21, 8'd3, 1'b0, 8'h00, 0, 1'b1);
    check_eq("overlap", {24'd0, mem[8'h23]}, 32'h55);
`ifdef DMEM_FILL_EN
    run_copy(8'h00, 8'h40, 8'd5, 1'b1, 8'hEE, 0, 1'b0);
    run_copy(8'h00, 8'hFD, 8'd4, 1'b1, 8'h3C, 2, 1'b0);
`endif

    // Randomized copies
    for (int n = 0; n < 14; n++) begin
      fl = 1'b0;
`ifdef DMEM_FILL_EN
      fl = 1'($urandom_range(0, 1));
`endif
      run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), fl, 8'($urandom),
               (n % 5 == 4) ? 2 : int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-copy aborts with no further writes and no done pulse
    begin
      int wr_after, done_after, busy_rst;
      DmaSrc = 8'h00; DmaDst = 8'h90; DmaLen = 8'd20; DmaFill = 1'b0; DmaStart = 1'b1;
      @(posedge Clk); #1;
      DmaStart = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      check_eq("midcopy_busy", {31'd0, DmaBusy}, 32'd1);
      Reset = 1'b1; CoreReq = 1'b1; CoreWe = 1'b1;
      #1;
      check_eq("rst_we_force", {31'd0, MemWriteEn}, 32'd0);
      busy_rst = 0;
      repeat (2) begin
        @(posedge Clk); #1;
        if (DmaBusy || MemWriteEn) busy_rst++;
      end
      check_eq("rst_abort", busy_rst, 0);
      Reset = 1'b0; CoreReq = 1'b0; CoreWe = 1'b0;
      wr_after = 0; done_after = 0;
      repeat (50) begin
        @(posedge Clk); #1;
        if (MemWriteEn) wr_after++;
        if (DmaDone || DmaBusy) done_after++;
      end
      check_eq("rst_no_wr", wr_after, 0);
      check_eq("rst_no_done", done_after, 0);
      $display("reset mid-copy writes_after=%0d done_after=%0d", wr_after, done_after);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
